// File: rtl/pipe_stage_chain.sv
// Parametrised inter-stage pipeline latch chain with per-stage valid bits,
// flush-over-stall priority, zeroed bubbles, occupancy and stall/flush stats.
module pipe_stage_chain #(
  parameter int W     = 64,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16,
  parameter int OCC_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             Enable_in,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             valid_out,
  output logic             Enable_out,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [DEPTH-1:0][W-1:0] data_q = '0;
  logic [DEPTH-1:0][W-1:0] data_d;
  logic [DEPTH-1:0]        vld_q = '0;
  logic [DEPTH-1:0]        vld_d;
  logic                    en_q = 1'b0;
  logic                    en_d;
  logic [OCC_W-1:0]        occ_q = '0;
  logic [OCC_W-1:0]        occ_d;
  logic [CNT_W-1:0]        stall_q = '0;
  logic [CNT_W-1:0]        stall_d;
  logic [CNT_W-1:0]        flush_q = '0;
  logic [CNT_W-1:0]        flush_d;

  always_comb begin
    data_d  = data_q;
    vld_d   = vld_q;
    occ_d   = occ_q;
    stall_d = stall_q;
    flush_d = flush_q;
    en_d    = Enable_in;
    if (flush) begin
      data_d = '0;
      vld_d  = '0;
      occ_d  = '0;
      if (flush_q != '1)
        flush_d = flush_q + CNT_W'(1);
    end else if (Enable_in) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      // bubbles enter as all-zero so no stale control bits travel
      data_d[0] = valid_in ? din : '0;
      vld_d[0]  = valid_in;
      occ_d     = occ_q + OCC_W'(valid_in)
                - OCC_W'(vld_q[DEPTH-1]);
    end else begin
      if (stall_q != '1)
        stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q  <= '0;
      vld_q   <= '0;
      en_q    <= 1'b0;
      occ_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      data_q  <= data_d;
      vld_q   <= vld_d;
      en_q    <= en_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign dout       = data_q[DEPTH-1];
  assign valid_out  = vld_q[DEPTH-1];
  assign Enable_out = en_q;
  assign occupancy  = occ_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: three depths driven in lockstep and compared
// against a queue-of-tokens reference model plus directed literal checks.
module tb_pipe_stage_chain;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic       fl  = 1'b0;
  logic       vin = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] a_do, b_do, c_do;
  logic       a_vo, b_vo, c_vo;
  logic       a_eo, b_eo, c_eo;
  logic [3:0] a_oc, b_oc, c_oc;
  logic [2:0] a_sc, a_fc;
  logic [15:0] b_sc, b_fc;
  logic [3:0] c_sc, c_fc;

  always #5 clk = ~clk;

  pipe_stage_chain #(.W(8), .DEPTH(3), .CNT_W(3), .OCC_W(4)) u_a (
    .clk(clk), .clr(clr), .Enable_in(en), .flush(fl),
    .valid_in(vin), .din(din), .dout(a_do), .valid_out(a_vo),
    .Enable_out(a_eo), .occupancy(a_oc),
    .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipe_stage_chain #(.W(8), .DEPTH(1), .CNT_W(16), .OCC_W(4)) u_b (
    .clk(clk), .clr(clr), .Enable_in(en), .flush(fl),
    .valid_in(vin), .din(din), .dout(b_do), .valid_out(b_vo),
    .Enable_out(b_eo), .occupancy(b_oc),
    .stall_cnt(b_sc), .flush_cnt(b_fc));

  pipe_stage_chain #(.W(8), .DEPTH(2), .CNT_W(4), .OCC_W(4)) u_c (
    .clk(clk), .clr(clr), .Enable_in(en), .flush(fl),
    .valid_in(vin), .din(din), .dout(c_do), .valid_out(c_vo),
    .Enable_out(c_eo), .occupancy(c_oc),
    .stall_cnt(c_sc), .flush_cnt(c_fc));

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } tok_t;

  int   dep[3] = '{3, 1, 2};
  int   cw[3]  = '{3, 16, 4};
  tok_t hist[3][$];
  int   m_sc[3];
  int   m_fc[3];
  logic m_en[3];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic empty_chain(input int i);
    tok_t z;
    z = '0;
    hist[i].delete();
    for (int k = 0; k < dep[i]; k++) hist[i].push_back(z);
  endtask

  task automatic model_edge();
    tok_t t;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        empty_chain(i);
        m_sc[i] = 0;
        m_fc[i] = 0;
        m_en[i] = 1'b0;
      end else if (fl) begin
        empty_chain(i);
        m_fc[i]++;
        m_en[i] = en;
      end else if (en) begin
        t.v = vin;
        t.d = vin ? din : 8'h00;
        hist[i].push_back(t);
        void'(hist[i].pop_front());
        m_en[i] = 1'b1;
      end else begin
        m_sc[i]++;
        m_en[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] gd;
    logic       gv, ge;
    logic [3:0] go;
    logic [15:0] gs, gf;
    int occ;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin gd = a_do; gv = a_vo; ge = a_eo; go = a_oc;
                 gs = 16'(a_sc); gf = 16'(a_fc); end
        1: begin gd = b_do; gv = b_vo; ge = b_eo; go = b_oc;
                 gs = b_sc; gf = b_fc; end
        default: begin gd = c_do; gv = c_vo; ge = c_eo; go = c_oc;
                 gs = 16'(c_sc); gf = 16'(c_fc); end
      endcase
      occ = 0;
      foreach (hist[i][k]) if (hist[i][k].v) occ++;
      chk($sformatf("u%0d.dout", i), 32'(gd), 32'(hist[i][0].d));
      chk($sformatf("u%0d.valid", i), 32'(gv), 32'(hist[i][0].v));
      chk($sformatf("u%0d.en_out", i), 32'(ge), 32'(m_en[i]));
      chk($sformatf("u%0d.occ", i), 32'(go), 32'(occ));
      chk($sformatf("u%0d.stall", i), 32'(gs),
          32'(sat(m_sc[i], cw[i])));
      chk($sformatf("u%0d.flush", i), 32'(gf),
          32'(sat(m_fc[i], cw[i])));
    end
  endtask

  task automatic step(input logic c, input logic f, input logic e,
                      input logic v, input logic [7:0] d);
    clr = c; fl = f; en = e; vin = v; din = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      empty_chain(i);
      m_sc[i] = 0;
      m_fc[i] = 0;
      m_en[i] = 1'b0;
    end
    #1;
    check_all();

    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h11);
    step(0, 0, 1, 1, 8'h22);
    step(0, 0, 1, 1, 8'h33);
    chk("lat_dout", 32'(a_do), 32'h11);
    chk("lat_valid", 32'(a_vo), 32'h1);
    chk("lat_occ", 32'(a_oc), 32'd3);
    chk("latch1", 32'(b_do), 32'h33);
    step(0, 0, 1, 1, 8'h44);
    chk("lat_next", 32'(a_do), 32'h22);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 8'h55);
    chk("stall_dout", 32'(a_do), 32'h22);
    chk("stall_cnt", 32'(a_sc), 32'd4);
    chk("stall_en", 32'(a_eo), 32'd0);
    step(0, 0, 1, 1, 8'h55);
    chk("resume", 32'(a_do), 32'h33);
    step(0, 0, 1, 1, 8'h66);
    step(0, 0, 1, 1, 8'h77);
    step(0, 1, 0, 1, 8'h88);
    chk("fl_occ", 32'(a_oc), 32'd0);
    chk("fl_cnt", 32'(a_fc), 32'd1);
    chk("fl_stall", 32'(a_sc), 32'd4);
    step(0, 0, 1, 0, 8'hFF);
    step(0, 0, 1, 0, 8'hFF);
    chk("bubble_d", 32'(c_do), 32'h00);
    chk("bubble_v", 32'(c_vo), 32'h0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 8'h00);
    chk("sat_a", 32'(a_sc), 32'd7);
    chk("sat_c", 32'(c_sc), 32'd14);
    step(0, 0, 1, 1, 8'hA1);
    step(0, 0, 1, 1, 8'hA2);
    step(0, 0, 1, 1, 8'hA3);
    step(1, 1, 1, 1, 8'hA4);
    chk("rst_dout", 32'(a_do), 32'h00);
    chk("rst_occ", 32'(a_oc), 32'd0);
    chk("rst_fc", 32'(a_fc), 32'd0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(99) < 2),
           ($urandom_range(99) < 6),
           ($urandom_range(99) < 75),
           ($urandom_range(99) < 70),
           8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
